// File: rtl/alu_op_decoder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_op_decoder_pkg
//  Description : Shared definitions for the LEGv8 ALU opcode decoder.
//                - ALU result-mux select encoding (SEL_*)
//                - LEGv8 opcode match values and don't-care masks
//                - decoded-result bundle {sel, sub, illegal}
//                - op_match() masked-compare helper
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_op_decoder_pkg;

    // Width of the opcode field, taken from instruction bits [31:21].
    localparam int OP_W = 11;

    // ALU result multiplexer select encoding.
    localparam logic [2:0] SEL_ADD = 3'd0;
    localparam logic [2:0] SEL_AND = 3'd1;
    localparam logic [2:0] SEL_XOR = 3'd2;
    localparam logic [2:0] SEL_OR  = 3'd3;
    localparam logic [2:0] SEL_B   = 3'd4;

    // LEGv8 opcode match values. Don't-care bits are zero here and are
    // excluded from the compare by the matching mask below.
    localparam logic [OP_W-1:0] OP_ADD  = 11'b10001011000;
    localparam logic [OP_W-1:0] OP_SUB  = 11'b11001011000;
    localparam logic [OP_W-1:0] OP_ADDI = 11'b10010001000;
    localparam logic [OP_W-1:0] OP_SUBI = 11'b11010001000;
    localparam logic [OP_W-1:0] OP_LDUR = 11'b11111000010;
    localparam logic [OP_W-1:0] OP_STUR = 11'b11111000000;
    localparam logic [OP_W-1:0] OP_AND  = 11'b10001010000;
    localparam logic [OP_W-1:0] OP_EOR  = 11'b11001010000;
    localparam logic [OP_W-1:0] OP_ORR  = 11'b10101010000;
    localparam logic [OP_W-1:0] OP_CBZ  = 11'b10110100000;

    // Masks: 1 = bit participates in the compare.
    localparam logic [OP_W-1:0] MASK_R   = 11'b11111111111; // R/D-format, exact
    localparam logic [OP_W-1:0] MASK_I   = 11'b11111111110; // I-format, 10-bit opcode
    localparam logic [OP_W-1:0] MASK_CB  = 11'b11111111000; // CB-format, 8-bit opcode

    // Decoded result carried through the pipeline register.
    typedef struct packed {
        logic [2:0] sel;
        logic       sub;
        logic       illegal;
    } alu_dec_t;

    // True when op equals val on every bit selected by mask.
    function automatic logic op_match(
        input logic [OP_W-1:0] op,
        input logic [OP_W-1:0] val,
        input logic [OP_W-1:0] mask
    );
        return ((op ^ val) & mask) == '0;
    endfunction

endpackage : alu_op_decoder_pkg
`default_nettype wire

// File: rtl/alu_op_decode_comb.sv
`default_nettype none
// ============================================================================
//  Module      : alu_op_decode_comb
//  Description : Pure combinational LEGv8 opcode -> ALU control decode.
//                Unrecognised opcodes decode to B pass-through, no subtract,
//                illegal flagged.
//  Ports       : opcode [OPW-1:0] in  - instruction bits [31:21]
//                dec    alu_dec_t out - {sel, sub, illegal}
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_op_decode_comb
    import alu_op_decoder_pkg::*;
#(
    parameter int OPW = 11
) (
    input  logic [OPW-1:0] opcode,
    output alu_dec_t       dec
);

    // The decode table is defined on the 11-bit LEGv8 field; take the top
    // OP_W bits so a wider opcode bus still lines up with bits [31:21].
    logic [OP_W-1:0] w_op;
    assign w_op = opcode[OPW-1 -: OP_W];

    always_comb begin
        dec = '{sel: SEL_B, sub: 1'b0, illegal: 1'b1};

        if (op_match(w_op, OP_ADD, MASK_R)  ||
            op_match(w_op, OP_ADDI, MASK_I) ||
            op_match(w_op, OP_LDUR, MASK_R) ||
            op_match(w_op, OP_STUR, MASK_R)) begin
            // Loads/stores use the adder for address generation.
            dec = '{sel: SEL_ADD, sub: 1'b0, illegal: 1'b0};
        end else if (op_match(w_op, OP_SUB, MASK_R) ||
                     op_match(w_op, OP_SUBI, MASK_I)) begin
            dec = '{sel: SEL_ADD, sub: 1'b1, illegal: 1'b0};
        end else if (op_match(w_op, OP_AND, MASK_R)) begin
            dec = '{sel: SEL_AND, sub: 1'b0, illegal: 1'b0};
        end else if (op_match(w_op, OP_EOR, MASK_R)) begin
            dec = '{sel: SEL_XOR, sub: 1'b0, illegal: 1'b0};
        end else if (op_match(w_op, OP_ORR, MASK_R)) begin
            dec = '{sel: SEL_OR, sub: 1'b0, illegal: 1'b0};
        end else if (op_match(w_op, OP_CBZ, MASK_CB)) begin
            // CBZ tests the register operand for zero: pass B straight through.
            dec = '{sel: SEL_B, sub: 1'b0, illegal: 1'b0};
        end
    end

endmodule : alu_op_decode_comb
`default_nettype wire

// File: rtl/alu_op_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : alu_op_decoder
//  Description : Registered LEGv8 opcode decoder driving the ALU result-mux
//                select (0 ADD, 1 AND, 2 XOR, 3 OR, 4 B) and subtract control.
//                One valid/ready pipeline stage, one-cycle latency, full
//                throughput. Illegal opcodes flow through flagged.
//  Macro       : ALU_DEC_ERRCNT_EN - adds err_count, a saturating count of
//                accepted illegal opcodes (cleared only by reset).
//  Ports       : clk, reset (sync, active-high)
//                in_valid/in_ready/opcode   - upstream handshake
//                out_valid/out_ready        - downstream handshake
//                sel[2:0], sub, illegal     - registered decode
//                err_count[CNTW-1:0]        - only with ALU_DEC_ERRCNT_EN
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_op_decoder
    import alu_op_decoder_pkg::*;
#(
    parameter int OPW  = 11,
    parameter int CNTW = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OPW-1:0]  opcode,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2:0]      sel,
    output logic            sub,
    output logic            illegal
`ifdef ALU_DEC_ERRCNT_EN
    ,
    output logic [CNTW-1:0] err_count
`endif
);

    alu_dec_t w_dec;
    alu_dec_t r_dec;
    logic     r_valid;
    logic     w_accept;

    alu_op_decode_comb #(
        .OPW    (OPW)
    ) u_decode (
        .opcode (opcode),
        .dec    (w_dec)
    );

    // Ready whenever the stage is empty or being drained this cycle; held low
    // during reset so no upstream handshake completes in the reset cycle.
    assign in_ready = !reset && (!r_valid || out_ready);
    assign w_accept = in_valid && in_ready;

    // A new accept always wins over a drain, so an accept+drain edge simply
    // replaces the entry and keeps valid high. Decode fields are not cleared
    // on drain; they hold the last value.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_dec   <= '0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_dec   <= w_dec;
        end else if (r_valid && out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid = r_valid;
    assign sel       = r_dec.sel;
    assign sub       = r_dec.sub;
    assign illegal   = r_dec.illegal;

`ifdef ALU_DEC_ERRCNT_EN
    localparam logic [CNTW-1:0] c_cnt_max = '1;

    logic [CNTW-1:0] r_err_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_err_count <= '0;
        end else if (w_accept && w_dec.illegal && (r_err_count != c_cnt_max)) begin
            r_err_count <= r_err_count + 1'b1;
        end
    end

    assign err_count = r_err_count;
`else
    // Counter width only matters when the counter is built; keep the
    // parameter referenced so both builds elaborate identically otherwise.
    if (CNTW < 1) begin : g_cntw_unused
    end
`endif

endmodule : alu_op_decoder
`default_nettype wire

// File: tb/tb_alu_op_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_op_decoder
//  Description : Self-checking bench for alu_op_decoder. A behavioural model
//                decodes opcodes from textual bit patterns and tracks the
//                single-entry valid/ready stage; a negedge process compares
//                the DUT against it every cycle. Directed sequences pin the
//                model with literal expectations, then randomized traffic runs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_op_decoder;

    localparam int OPW  = 11;
    localparam int CNTW = 2;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            in_valid = 1'b1;
    logic            in_ready;
    logic [OPW-1:0]  opcode = 11'b10001011000;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [2:0]      sel;
    logic            sub;
    logic            illegal;
`ifdef ALU_DEC_ERRCNT_EN
    logic [CNTW-1:0] err_count;
`endif

    alu_op_decoder #(
        .OPW       (OPW),
        .CNTW      (CNTW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sel       (sel),
        .sub       (sub),
        .illegal   (illegal)
`ifdef ALU_DEC_ERRCNT_EN
        ,
        .err_count (err_count)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    bit en     = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Decode table as written in the instruction-set documentation.
    string    pats [10] = '{"10001011000", "11001011000", "1001000100x", "1101000100x",
                            "11111000010", "11111000000", "10001010000", "11001010000",
                            "10101010000", "10110100xxx"};
    int       psel [10] = '{0, 0, 0, 0, 0, 0, 1, 2, 3, 4};
    bit       psub [10] = '{0, 1, 0, 1, 0, 0, 0, 0, 0, 0};

    function automatic bit pat_hit(input logic [10:0] op, input string p);
        for (int i = 0; i < 11; i++) begin
            byte c = p[i];
            if (c != "x" && op[10-i] != (c == "1")) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic void ref_dec(input logic [10:0] op, output int s, output bit b, output bit il);
        s = 4; b = 1'b0; il = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (pat_hit(op, pats[k])) begin
                s = psel[k]; b = psub[k]; il = 1'b0;
            end
        end
    endfunction

    bit m_valid = 1'b0;
    int m_sel   = 0;
    bit m_sub   = 1'b0;
    bit m_ill   = 1'b0;
    int m_cnt   = 0;

    always @(posedge clk) begin
        if (reset) begin
            m_valid = 1'b0; m_sel = 0; m_sub = 1'b0; m_ill = 1'b0; m_cnt = 0;
        end else if (in_valid && (!m_valid || out_ready)) begin
            m_valid = 1'b1;
            ref_dec(opcode, m_sel, m_sub, m_ill);
            if (m_ill && m_cnt < (1 << CNTW) - 1) m_cnt++;
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (en) begin
            chk("m_out_valid", 32'(out_valid), 32'(m_valid));
            chk("m_in_ready",  32'(in_ready),  32'(!reset && (!m_valid || out_ready)));
            chk("m_sel",       32'(sel),       32'(m_sel));
            chk("m_sub",       32'(sub),       32'(m_sub));
            chk("m_illegal",   32'(illegal),   32'(m_ill));
`ifdef ALU_DEC_ERRCNT_EN
            chk("m_err_count", 32'(err_count), 32'(m_cnt));
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [10:0] tbl_op  [8] = '{11'b10001011000, 11'b11001011000, 11'b10010001001, 11'b10001010000,
                                 11'b11001010000, 11'b10101010000, 11'b11111000010, 11'b10110100101};
    int          tbl_sel [8] = '{0, 0, 0, 1, 2, 3, 0, 4};
    bit          tbl_sub [8] = '{0, 1, 0, 0, 0, 0, 0, 0};
    int          sat_exp [5] = '{1, 2, 3, 3, 3};
    logic [10:0] rnd_base [10] = '{11'b10001011000, 11'b11001011000, 11'b10010001000, 11'b11010001000,
                                   11'b11111000010, 11'b11111000000, 11'b10001010000, 11'b11001010000,
                                   11'b10101010000, 11'b10110100000};

    initial begin
        // Reset held two cycles with an ADD offered.
        for (int i = 0; i < 2; i++) begin
            step();
            en = 1'b1;
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_sel",       32'(sel),       32'd0);
            chk("rst_sub",       32'(sub),       32'd0);
            chk("rst_illegal",   32'(illegal),   32'd0);
            chk("rst_in_ready",  32'(in_ready),  32'd0);
        end
        reset = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Full table streamed back to back.
        for (int i = 0; i < 8; i++) begin
            opcode = tbl_op[i];
            step();
            chk("tbl_valid",   32'(out_valid), 32'd1);
            chk("tbl_sel",     32'(sel),       32'(tbl_sel[i]));
            chk("tbl_sub",     32'(sub),       32'(tbl_sub[i]));
            chk("tbl_illegal", 32'(illegal),   32'd0);
        end

        // Backpressure.
        opcode = 11'b10101010000;
        step();
        chk("bp_orr_sel", 32'(sel), 32'd3);
        out_ready = 1'b0;
        opcode    = 11'b10001010000;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_hold_sel",      32'(sel),       32'd3);
            chk("bp_hold_in_ready", 32'(in_ready),  32'd0);
            chk("bp_hold_valid",    32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        step();
        chk("bp_release_sel", 32'(sel), 32'd1);

        // Illegal opcodes and counter saturation, from a clean reset.
        reset = 1'b1;
        step();
        reset  = 1'b0;
        opcode = 11'b00000000000;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("ill_sel",     32'(sel),     32'd4);
            chk("ill_sub",     32'(sub),     32'd0);
            chk("ill_illegal", 32'(illegal), 32'd1);
`ifdef ALU_DEC_ERRCNT_EN
            chk("ill_err_count", 32'(err_count), 32'(sat_exp[i]));
`endif
        end

        // Reset asserted while stalled.
        out_ready = 1'b0;
        step();
        chk("stall_valid", 32'(out_valid), 32'd1);
        reset = 1'b1;
        step();
        chk("stall_rst_valid",    32'(out_valid), 32'd0);
        chk("stall_rst_in_ready", 32'(in_ready),  32'd0);
`ifdef ALU_DEC_ERRCNT_EN
        chk("stall_rst_err_count", 32'(err_count), 32'd0);
`endif
        reset = 1'b0;

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            int pick;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            reset     = ($urandom_range(0, 199) == 0);
            pick      = $urandom_range(0, 12);
            if (pick < 10) begin
                opcode = rnd_base[pick];
                if ($urandom_range(0, 1) == 1) opcode = opcode ^ 11'($urandom_range(0, 7));
            end else begin
                opcode = 11'($urandom);
            end
            step();
        end

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_alu_op_decoder
`default_nettype wire

// File: doc/alu_op_decoder.md
# alu_op_decoder

Registered opcode decoder that drives the ALU result multiplexer's 3-bit select and subtract control from LEGv8 instruction opcodes. It sits between instruction fetch/decode and the datapath: it accepts one 11-bit opcode per handshake, decodes it, and presents the select word one cycle later behind a valid/ready pipeline register. It is the producing end of the mux select interface (encoding 0 ADD, 1 AND, 2 XOR, 3 OR, 4 B pass-through).

## Interface
- OPW, 11: opcode width (instruction bits [31:21]).
- CNTW, 8: illegal-opcode counter width (used only with ALU_DEC_ERRCNT_EN).
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  opcode present.
- in_ready  output  1  decoder can accept.
- opcode  input  OPW  instruction bits [31:21].
- out_valid  output  1  decoded result present.
- out_ready  input  1  consumer accepts.
- sel  output  3  mux select (0 ADD, 1 AND, 2 XOR, 3 OR, 4 B).
- sub  output  1  invert B and carry-in 1 (only with sel=0).
- illegal  output  1  opcode not recognised.
- err_count  output  CNTW  saturating illegal count (only with ALU_DEC_ERRCNT_EN).

## Operation
- Decode table (x = don't care): ADD 10001011000 -> sel 0, sub 0; SUB 11001011000 -> 0/1; ADDI 1001000100x -> 0/0; SUBI 1101000100x -> 0/1; LDUR 11111000010 and STUR 11111000000 -> 0/0 (address add); AND 10001010000 -> 1/0; EOR 11001010000 -> 2/0; ORR 10101010000 -> 3/0; CBZ 10110100xxx -> 4/0 (pass B for zero test).
- Any other opcode: sel 4, sub 0, illegal 1. Illegal results still flow through the handshake; they are not dropped.
- Single pipeline register holding {sel, sub, illegal} plus out_valid.
- in_ready = !out_valid || out_ready (combinational; full throughput, no bubbles).
- Load when in_valid && in_ready: register takes new decode, out_valid <= 1.
- Drain when out_valid && out_ready && !in_valid: out_valid <= 0; sel/sub/illegal hold last value.
- While out_valid && !out_ready: outputs are stable; opcode input ignored.
- Simultaneous accept and drain: new entry replaces old in same edge, out_valid stays 1.

## Timing
- Latency: 1 cycle from accepted opcode to out_valid.
- Throughput: 1 opcode/cycle when out_ready held high.
- Reset (synchronous): out_valid 0, sel 0, sub 0, illegal 0, err_count 0; in_ready reads 1 the cycle after reset deasserts (and during reset, in_ready is forced 0).
- Reset asserted mid-stall discards the held entry; no output handshake completes in the reset cycle.
- Outputs sel/sub/illegal are registered only; no combinational input-to-output path except out_ready -> in_ready.

## Configuration
- ALU_DEC_ERRCNT_EN defined: err_count port present; increments by 1 on each accepted illegal opcode, saturates at 2^CNTW-1, cleared only by reset.
- Not defined: err_count port and counter logic absent; all other behaviour identical.

## Structure
- Shared package: sel encoding constants (SEL_ADD=0, SEL_AND=1, SEL_XOR=2, SEL_OR=3, SEL_B=4), LEGv8 opcode constants and masks, decoded-result bundle type {sel, sub, illegal}.
- One sub-module natural: alu_op_decode_comb (pure combinational opcode -> bundle), instanced ahead of the pipeline register.

## Test plan
- Reset: hold reset 2 cycles with in_valid=1, opcode=ADD -> out_valid 0, sel 0, sub 0, illegal 0, in_ready 0 throughout.
- Full table: stream ADD, SUB, ADDI(10010001001), AND, EOR, ORR, LDUR, CBZ(10110100101) with out_ready=1 -> one result per cycle, sel 0,0,0,1,2,3,0,4; sub 0,1,0,0,0,0,0,0; illegal all 0.
- Backpressure: accept ORR, hold out_ready=0 3 cycles while opcode=AND -> sel stays 3, in_ready 0; release -> sel 1 next cycle.
- Illegal: opcode 00000000000 -> sel 4, sub 0, illegal 1; with ALU_DEC_ERRCNT_EN, err_count 0->1.
- Saturation (ALU_DEC_ERRCNT_EN, CNTW=2): 5 illegal opcodes -> err_count 1,2,3,3,3.
- Mid-stall reset: out_valid=1, out_ready=0, pulse reset -> out_valid 0 next cycle, err_count 0.
